// File: rtl/shader_sequencer_if.sv
// shader_sequencer_if: control/data bus between the sequencer (master) and one shader_core (slave)
//   write_enable/write_addr/write_data : register write port of the core
//   addr_a/addr_b/op/mask              : ALU operand selects, operation and lane mask
//   result                             : combinational ALU result returned by the core
interface shader_sequencer_if;
  logic        write_enable;
  logic [2:0]  write_addr;
  logic [31:0] write_data;
  logic [2:0]  addr_a;
  logic [2:0]  addr_b;
  logic [1:0]  op;
  logic [3:0]  mask;
  logic [31:0] result;
  modport master(output write_enable, write_addr, write_data, addr_a, addr_b, op, mask, input result);
  modport slave(input write_enable, write_addr, write_data, addr_a, addr_b, op, mask, output result);
endinterface

// File: rtl/shader_sequencer.sv
// shader_sequencer: program-RAM micro-sequencer that fetches, executes and writes back ALU/LDI ops on a shader_core
//   clk/rst                      : clock, synchronous active-high reset
//   prog_we/prog_addr/prog_data  : program RAM write port, taken only while idle
//   start                        : begin execution at pc 0 (idle only)
//   busy/done/err/pc/retired     : run status, done pulse, sticky error, program counter, retired count
//   core                         : master side of the shader_core bus
module shader_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int PC_W       = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_we,
  input  logic [PC_W-1:0]  prog_addr,
  input  logic [19:0]      prog_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] retired,
  shader_sequencer_if.master core
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, DONE} state_t;
  localparam logic [1:0] C_ALU = 2'b00, C_LDI = 2'b01;
  localparam logic [PC_W-1:0] LAST = PC_W'(PROG_DEPTH - 1);
  state_t state, state_n;
  logic [19:0] prog_mem [PROG_DEPTH];
  logic [19:0] ir;
  logic [31:0] res_q;
  logic [1:0] cls;
  logic alu_exec, wb;
  assign cls = ir[19:18];
  assign alu_exec = state == EXEC && cls == C_ALU;
  // the reset-cycle gate keeps an in-flight write-back from reaching the core
  assign wb = state == WB && !rst;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign core.write_enable = wb;
  assign core.write_addr = wb ? ir[15:13] : 3'd0;
  assign core.write_data = wb ? res_q : 32'd0;
  assign core.addr_a = alu_exec ? ir[12:10] : 3'd0;
  assign core.addr_b = alu_exec ? ir[9:7] : 3'd0;
  assign core.op = alu_exec ? ir[17:16] : 2'd0;
  assign core.mask = alu_exec ? ir[6:3] : 4'd0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? FETCH : IDLE;
      FETCH:   state_n = EXEC;
      EXEC:    state_n = (cls == C_ALU || cls == C_LDI) ? WB : DONE;
      WB:      state_n = pc == LAST ? DONE : FETCH;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (state == IDLE && prog_we) prog_mem[prog_addr] <= prog_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      retired <= '0;
      err <= 1'b0;
      ir <= '0;
      res_q <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          pc <= '0;
          retired <= '0;
          err <= 1'b0;
        end
        FETCH: ir <= prog_mem[pc];
        EXEC: begin
          res_q <= cls == C_LDI ? {4{ir[7:0]}} : core.result;
          if (cls == 2'b11) err <= 1'b1;
        end
        WB: begin
          retired <= &retired ? retired : retired + CNT_W'(1);
          if (pc == LAST) err <= 1'b1;
          else pc <= pc + PC_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_shader_sequencer.sv
// tb_shader_sequencer: directed self-checking bench with a behavioural shader_core on the bus
module tb_shader_sequencer;
  logic clk = 0, rst = 1, prog_we = 0, start = 0;
  logic [3:0] prog_addr = 0;
  logic [19:0] prog_data = 0;
  logic busy, done, err;
  logic [3:0] pc;
  logic [15:0] retired;
  int errors = 0, checks = 0;
  int nw = 0, base = 0, cyc = 0;
  logic [2:0] wa [256];
  logic [31:0] wd [256];
  logic [31:0] regs [8] = '{default: 32'd0};
  logic [3:0] last_mask = 0;
  logic [3:0] pc_prev = 0;
  logic busy_prev = 0, wrapped = 0, done_busy = 0;
  shader_sequencer_if bus();
  shader_sequencer dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .busy(busy), .done(done), .err(err), .pc(pc), .retired(retired), .core(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] lane_op(logic [1:0] op, logic [7:0] a, logic [7:0] b);
    return op == 2'd0 ? a + b : op == 2'd1 ? a * b : op == 2'd2 ? a - b : a ^ b;
  endfunction
  always_comb begin
    bus.result = 32'd0;
    for (int i = 0; i < 4; i++)
      if (bus.mask[i]) bus.result[8*i +: 8] = lane_op(bus.op, regs[bus.addr_a][8*i +: 8], regs[bus.addr_b][8*i +: 8]);
  end
  always @(posedge clk) begin
    if (bus.write_enable) begin
      if (nw < 256) begin
        wa[nw] = bus.write_addr;
        wd[nw] = bus.write_data;
      end
      nw++;
      regs[bus.write_addr] = bus.write_data;
    end
    if (bus.mask != 0) last_mask = bus.mask;
    if (busy && busy_prev && pc_prev == 4'd15 && pc == 4'd0) wrapped = 1;
    busy_prev = busy;
    pc_prev = pc;
  end
  function automatic logic [19:0] ldi(logic [2:0] dst, logic [7:0] imm);
    return {2'b01, 2'b00, dst, 5'b0, imm};
  endfunction
  function automatic logic [19:0] alu(logic [1:0] op, logic [2:0] dst, logic [2:0] a, logic [2:0] b, logic [3:0] m);
    return {2'b00, op, dst, a, b, m, 3'b0};
  endfunction
  localparam logic [19:0] HALT = 20'h80000;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic load(int a, logic [19:0] d);
    prog_we = 1;
    prog_addr = a[3:0];
    prog_data = d;
    @(negedge clk);
    prog_we = 0;
  endtask
  function automatic logic [31:0] wdat(int k);
    return (base + k < 256 && base + k < nw) ? wd[base + k] : 32'hDEADBEEF;
  endfunction
  function automatic logic [31:0] wadr(int k);
    return (base + k < 256 && base + k < nw) ? 32'(wa[base + k]) : 32'hDEADBEEF;
  endfunction
  // caller sits at a negedge; cyc counts cycles after the start edge; inj>0 pulses start+prog_we in that cycle
  task automatic run(int inj);
    base = nw;
    start = 1;
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 200) begin
      if (cyc == inj) begin
        start = 1;
        prog_we = 1;
        prog_addr = 4'd2;
        prog_data = ldi(3'd3, 8'hAA);
      end else begin
        start = 0;
        prog_we = 0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 0;
    prog_we = 0;
    done_busy = busy;
    @(negedge clk);
  endtask
  task automatic load_basic();
    load(0, ldi(3'd1, 8'h03));
    load(1, ldi(3'd2, 8'h05));
    load(2, alu(2'd0, 3'd3, 3'd1, 3'd2, 4'b1111));
    load(3, HALT);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_we", 32'(bus.write_enable), 0);
    rst = 0;
    @(negedge clk);
    // test 1: HALT written in the same cycle as start
    load(0, ldi(3'd1, 8'h03));
    load(1, ldi(3'd2, 8'h05));
    load(2, alu(2'd0, 3'd3, 3'd1, 3'd2, 4'b1111));
    prog_we = 1;
    prog_addr = 4'd3;
    prog_data = HALT;
    run(0);
    chk("t1_cycles", cyc, 12);
    chk("t1_busy_at_done", 32'(done_busy), 1);
    chk("t1_nwrites", nw - base, 3);
    chk("t1_w0", wdat(0), 32'h03030303);
    chk("t1_w1", wdat(1), 32'h05050505);
    chk("t1_w2", wdat(2), 32'h08080808);
    chk("t1_a2", wadr(2), 3);
    chk("t1_retired", 32'(retired), 3);
    chk("t1_err", 32'(err), 0);
    chk("t1_idle_busy", 32'(busy), 0);
    // test 2: masked MUL
    load(2, alu(2'd1, 3'd4, 3'd1, 3'd2, 4'b0101));
    run(0);
    chk("t2_cycles", cyc, 12);
    chk("t2_w2", wdat(2), 32'h000F000F);
    chk("t2_a2", wadr(2), 4);
    chk("t2_mask", 32'(last_mask), 4'b0101);
    // test 3: illegal class at addr 1
    load(1, 20'hC0000);
    run(0);
    chk("t3_cycles", cyc, 6);
    chk("t3_nwrites", nw - base, 1);
    chk("t3_err", 32'(err), 1);
    chk("t3_retired", 32'(retired), 1);
    // test 4: no HALT, PC overrun
    for (int i = 0; i < 16; i++) load(i, ldi(3'(i % 8), 8'(i)));
    run(0);
    chk("t4_cycles", cyc, 49);
    chk("t4_nwrites", nw - base, 16);
    chk("t4_last", wdat(15), 32'h0F0F0F0F);
    chk("t4_err", 32'(err), 1);
    chk("t4_pc", 32'(pc), 15);
    chk("t4_retired", 32'(retired), 16);
    chk("t4_wrap", 32'(wrapped), 0);
    // test 5: reset during ALU EXEC, then during a WB
    load_basic();
    base = nw;
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 0;
    while (bus.mask != 4'hF && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5_reach_exec", 32'(bus.mask), 4'hF);
    rst = 1;
    @(negedge clk);
    chk("t5_we", 32'(bus.write_enable), 0);
    chk("t5_nwrites", nw - base, 2);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_pc", 32'(pc), 0);
    chk("t5_retired", 32'(retired), 0);
    chk("t5_mask", 32'(bus.mask), 0);
    rst = 0;
    @(negedge clk);
    base = nw;
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 0;
    while (!bus.write_enable && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1;
    #1;
    chk("t5_wb_gate", 32'(bus.write_enable), 0);
    @(negedge clk);
    chk("t5_wb_nwrites", nw - base, 0);
    rst = 0;
    @(negedge clk);
    run(0);
    chk("t5_rerun_cycles", cyc, 12);
    chk("t5_rerun_w2", wdat(2), 32'h08080808);
    chk("t5_rerun_retired", 32'(retired), 3);
    // test 6: start and prog_we while busy are ignored
    run(3);
    chk("t6_cycles", cyc, 12);
    chk("t6_w2", wdat(2), 32'h08080808);
    run(0);
    chk("t6_ram_kept", wdat(2), 32'h08080808);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
